// File: rtl/dsm_pkg.sv
// ---------------------------------------------------------------------------
// dsm_pkg
//   Shared definitions for the fs/4 quadrature mixer family.
//   - lo_code_t : 2-bit ternary local-oscillator code
//                 2'b00 = 0, 2'b01 = +1, 2'b1x = -1
//   - LO_ZERO / LO_POS / LO_NEG : canonical code values
//   - lo_apply  : multiplies a signed sample by a ternary LO code
// ---------------------------------------------------------------------------
package dsm_pkg;

  typedef logic [1:0] lo_code_t;

  localparam lo_code_t LO_ZERO = 2'b00;
  localparam lo_code_t LO_POS  = 2'b01;
  localparam lo_code_t LO_NEG  = 2'b10;

  // Width of the generic sample port of lo_apply.
  // Callers sign-extend narrower samples into it and keep the low W+1 bits.
  localparam int LO_APPLY_W = 32;

  // Returns sample * code, one bit wider than the sample.
  // The extra bit means negating the most negative value cannot wrap.
  function automatic logic signed [LO_APPLY_W:0] lo_apply(
    input logic signed [LO_APPLY_W-1:0] sample,
    input lo_code_t                     code
  );
    logic signed [LO_APPLY_W:0] ext;
    ext = {sample[LO_APPLY_W-1], sample};
    if (code[1]) begin
      lo_apply = -ext;
    end else if (code[0]) begin
      lo_apply = ext;
    end else begin
      lo_apply = '0;
    end
  endfunction

endpackage

// File: rtl/iq_acc_dump.sv
// ---------------------------------------------------------------------------
// iq_acc_dump
//   One channel of the integrate-and-dump decimator.
//   It accumulates signed product terms over a block of 2**DECIM_LOG2 accepted
//   samples. On the last sample of a block, it registers the gain-normalised
//   sum and clears the accumulator.
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-high reset
//   restart    in   discard the partial block; a same-cycle sample starts a new block
//   in_valid   in   term holds a new product this cycle
//   last       in   this accepted sample completes the block
//   term       in   W+1-bit signed product (sample x LO code)
//   demod      out  W-bit decimated result, held between dumps
// ---------------------------------------------------------------------------
module iq_acc_dump
  import dsm_pkg::*;
#(
  parameter int W          = 15,
  parameter int DECIM_LOG2 = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                restart,
  input  logic                in_valid,
  input  logic                last,
  input  logic signed [W:0]   term,
  output logic signed [W-1:0] demod
);

  localparam int AW = W + 1 + DECIM_LOG2;

  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [W-1:0]  demod_q, demod_d;

  logic signed [AW-1:0] term_ext;
  logic signed [AW-1:0] sum;
  logic signed [AW-1:0] sum_shift;
  logic                 unused_shift_hi;

  assign term_ext = AW'(term);
  assign sum      = acc_q + term_ext;

  // DECIM terms summed, then divided by DECIM/2. An fs/4 tone of
  // amplitude A therefore comes out with magnitude A.
  // The bounded input range guarantees that the top bits are only sign copies.
  assign sum_shift       = sum >>> (DECIM_LOG2 - 1);
  assign unused_shift_hi = ^sum_shift[AW-1:W];

  always_comb begin
    acc_d   = acc_q;
    demod_d = demod_q;
    if (restart) begin
      acc_d = in_valid ? term_ext : '0;
    end else if (in_valid) begin
      if (last) begin
        demod_d = sum_shift[W-1:0];
        acc_d   = '0;
      end else begin
        acc_d = sum;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_q   <= '0;
      demod_q <= '0;
    end else begin
      acc_q   <= acc_d;
      demod_q <= demod_d;
    end
  end

  assign demod = demod_q;

endmodule

// File: rtl/iq_demixer.sv
// ---------------------------------------------------------------------------
// iq_demixer
//   Quadrature down-converter with an fs/4 ternary LO (cos / -sin).
//   A real sample stream is mixed into I and Q products. Each channel is
//   integrated and dumped over 2**DECIM_LOG2 samples to produce decimated
//   baseband words, and out_valid pulses for one cycle after each dump.
// Ports
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-high reset, clears all state
//   in_valid    in   mix_in carries a new sample
//   mix_in      in   W-bit signed real sample
//   phase_sync  in   restart the LO phase and the integration block
//   out_valid   out  one-cycle pulse: demod_i / demod_q updated
//   demod_i     out  W-bit signed in-phase result
//   demod_q     out  W-bit signed quadrature result
//   lo_i        out  LO code currently applied to I (decoded from phase)
//   lo_q        out  LO code currently applied to Q
// Parameters: W up to 30; DECIM_LOG2 in 1..6.
// ---------------------------------------------------------------------------
module iq_demixer
  import dsm_pkg::*;
#(
  parameter int W          = 15,
  parameter int DECIM_LOG2 = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic signed [W-1:0] mix_in,
  input  logic                phase_sync,
  output logic                out_valid,
  output logic signed [W-1:0] demod_i,
  output logic signed [W-1:0] demod_q,
  output logic [1:0]          lo_i,
  output logic [1:0]          lo_q
);

  localparam int DECIM = 1 << DECIM_LOG2;
  localparam int CW    = DECIM_LOG2;

  // Channel index: 0 = I, 1 = Q
  localparam int NCH = 2;

  logic [1:0]    ph_q, ph_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;

  logic          last;
  logic [1:0]    ph_eff;

  lo_code_t              code_cur [NCH];
  lo_code_t              code_eff [NCH];
  logic signed [W:0]     term     [NCH];
  logic signed [W-1:0]   demod    [NCH];

  // fs/4 LO table: I follows cos, Q follows -sin.
  function automatic lo_code_t lo_table(input logic [1:0] ph, input int ch);
    lo_code_t c;
    c = LO_ZERO;
    if (ch == 0) begin
      case (ph)
        2'd0:    c = LO_POS;
        2'd2:    c = LO_NEG;
        default: c = LO_ZERO;
      endcase
    end else begin
      case (ph)
        2'd1:    c = LO_NEG;
        2'd3:    c = LO_POS;
        default: c = LO_ZERO;
      endcase
    end
    return c;
  endfunction

  assign last = (cnt_q == CW'(DECIM - 1));

  // A sample that arrives together with phase_sync is mixed at phase 0.
  // This holds even though the phase register still shows the old phase.
  assign ph_eff = phase_sync ? 2'd0 : ph_q;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic signed [LO_APPLY_W:0] prod_full;
    logic                       unused_prod_hi;

    assign code_cur[gi] = lo_table(ph_q, gi);
    assign code_eff[gi] = lo_table(ph_eff, gi);

    assign prod_full      = lo_apply(LO_APPLY_W'(mix_in), code_eff[gi]);
    assign term[gi]       = prod_full[W:0];
    assign unused_prod_hi = ^prod_full[LO_APPLY_W:W+1];

    iq_acc_dump #(
      .W          (W),
      .DECIM_LOG2 (DECIM_LOG2)
    ) u_acc (
      .clock    (clock),
      .reset    (reset),
      .restart  (phase_sync),
      .in_valid (in_valid),
      .last     (last),
      .term     (term[gi]),
      .demod    (demod[gi])
    );
  end

  always_comb begin
    ph_d        = ph_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    if (phase_sync) begin
      // The restart never dumps. A same-cycle sample becomes sample 0 of the new block.
      ph_d  = in_valid ? 2'd1 : 2'd0;
      cnt_d = in_valid ? CW'(1) : '0;
    end else if (in_valid) begin
      ph_d        = ph_q + 2'd1;
      cnt_d       = last ? '0 : cnt_q + CW'(1);
      out_valid_d = last;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ph_q        <= 2'd0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ph_q        <= ph_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign demod_i   = demod[0];
  assign demod_q   = demod[1];
  assign lo_i      = code_cur[0];
  assign lo_q      = code_cur[1];

endmodule

// File: tb/tb_iq_demixer.sv
module tb_iq_demixer;

  localparam int W          = 15;
  localparam int DECIM_LOG2 = 3;
  localparam int DECIM      = 8;

  logic                clock = 1'b0;
  logic                reset;
  logic                in_valid;
  logic signed [W-1:0] mix_in;
  logic                phase_sync;
  logic                out_valid;
  logic signed [W-1:0] demod_i;
  logic signed [W-1:0] demod_q;
  logic [1:0]          lo_i;
  logic [1:0]          lo_q;

  int tests_run    = 0;
  int tests_failed = 0;
  int ov_count     = 0;
  int tb_cnt       = 0;

  typedef struct {
    int i;
    int q;
  } exp_t;

  exp_t sb[$];

  int cos_pat[8]  = '{8000, 0, -8000, 0, 8000, 0, -8000, 0};
  int sin_pat[8]  = '{0, 8000, 0, -8000, 0, 8000, 0, -8000};
  int dc_pat[8]   = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
  int ext_pat[8]  = '{16383, 0, -16384, 0, 16383, 0, -16384, 0};
  int next_pat[8] = '{-16384, 0, 16383, 0, -16384, 0, 16383, 0};

  iq_demixer #(
    .W          (W),
    .DECIM_LOG2 (DECIM_LOG2)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .mix_in     (mix_in),
    .phase_sync (phase_sync),
    .out_valid  (out_valid),
    .demod_i    (demod_i),
    .demod_q    (demod_q),
    .lo_i       (lo_i),
    .lo_q       (lo_q)
  );

  always #5 clock = ~clock;

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clock) begin
    exp_t e;
    if (reset === 1'b0 && out_valid === 1'b1) begin
      ov_count++;
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_dump: out_valid=1 got i=%0d q=%0d, required no output",
                 demod_i, demod_q);
      end else begin
        e = sb.pop_front();
        if (demod_i !== W'(e.i) || demod_q !== W'(e.q)) begin
          tests_failed++;
          $display("FAIL dump_value: got i=%0d q=%0d, required i=%0d q=%0d",
                   demod_i, demod_q, e.i, e.q);
        end else begin
          $display("[TB] dump ok i=%0d q=%0d", demod_i, demod_q);
        end
      end
    end
  end

  // One clock of stimulus. This also checks out_valid against the bench's own block counter.
  task automatic step(input logic v, input logic ps, input int x);
    logic exp_ov;
    exp_ov     = v && !ps && (tb_cnt == DECIM - 1);
    in_valid   = v;
    phase_sync = ps;
    mix_in     = W'(x);
    @(posedge clock);
    #1;
    if (ps) tb_cnt = v ? 1 : 0;
    else if (v) tb_cnt = (tb_cnt == DECIM - 1) ? 0 : tb_cnt + 1;
    tests_run++;
    if (out_valid !== exp_ov) begin
      tests_failed++;
      $display("FAIL out_valid_timing: got %b, required %b (v=%b ps=%b)", out_valid, exp_ov, v, ps);
    end
    in_valid   = 1'b0;
    phase_sync = 1'b0;
  endtask

  task automatic send_block(input int pat[8], input int ei, input int eq,
                            input int max_gap, input logic sync_first);
    exp_t e;
    e.i = ei;
    e.q = eq;
    sb.push_back(e);
    for (int k = 0; k < DECIM; k++) begin
      step(1'b1, (k == 0) && sync_first, pat[k]);
      if (max_gap > 0) begin
        int gap;
        gap = $urandom_range(0, max_gap);
        for (int g = 0; g < gap; g++) step(1'b0, 1'b0, 0);
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    tests_run++;
    if (out_valid !== 1'b0 || demod_i !== '0 || demod_q !== '0 ||
        lo_i !== 2'b01 || lo_q !== 2'b00) begin
      tests_failed++;
      $display("FAIL %s: got ov=%b i=%0d q=%0d lo_i=%b lo_q=%b, required 0 0 0 01 00",
               tag, out_valid, demod_i, demod_q, lo_i, lo_q);
    end else begin
      $display("[TB] %s ok", tag);
    end
  endtask

  task automatic test_reset;
    reset      = 1'b1;
    in_valid   = 1'b0;
    phase_sync = 1'b0;
    mix_in     = '0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_outputs("reset_state");
    reset  = 1'b0;
    tb_cnt = 0;
    step(1'b0, 1'b0, 0);
  endtask

  task automatic test_dc;
    send_block(dc_pat, 0, 0, 0, 1'b0);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
  endtask

  task automatic test_cos_sin;
    send_block(cos_pat, 8000, 0, 0, 1'b0);
    step(1'b0, 1'b0, 0);
    send_block(sin_pat, 0, -8000, 0, 1'b0);
    step(1'b0, 1'b0, 0);
  endtask

  task automatic test_extremes;
    send_block(ext_pat, 16383, 0, 0, 1'b0);
    send_block(next_pat, -16384, 0, 0, 1'b0);
    step(1'b0, 1'b0, 0);
  endtask

  task automatic test_phase_sync;
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, cos_pat[k]);
    step(1'b0, 1'b1, 0);
    tests_run++;
    if (lo_i !== 2'b01 || lo_q !== 2'b00) begin
      tests_failed++;
      $display("FAIL phase_sync_lo: got lo_i=%b lo_q=%b, required 01 00", lo_i, lo_q);
    end
    send_block(cos_pat, 8000, 0, 0, 1'b0);
    step(1'b0, 1'b0, 0);
    // Restart that carries a sample: that sample is block sample 0 at phase 0.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, sin_pat[k]);
    send_block(cos_pat, 8000, 0, 0, 1'b1);
    step(1'b0, 1'b0, 0);
  endtask

  task automatic test_back_to_back_gaps;
    int ov_before;
    ov_before = ov_count;
    send_block(cos_pat, 8000, 0, 5, 1'b0);
    send_block(sin_pat, 0, -8000, 5, 1'b0);
    send_block(cos_pat, 8000, 0, 5, 1'b0);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    tests_run++;
    if (ov_count - ov_before !== 3) begin
      tests_failed++;
      $display("FAIL gap_dump_count: got %0d dumps, required 3", ov_count - ov_before);
    end
  endtask

  task automatic test_reset_midcycle;
    send_block(cos_pat, 8000, 0, 0, 1'b0);
    step(1'b0, 1'b0, 0);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, cos_pat[k]);
    tests_run++;
    if (demod_i !== 15'sd8000 || lo_i !== 2'b00 || lo_q !== 2'b01) begin
      tests_failed++;
      $display("FAIL pre_reset_state: got i=%0d lo_i=%b lo_q=%b, required 8000 00 01",
               demod_i, lo_i, lo_q);
    end
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("reset_midcycle");
    @(posedge clock);
    #1;
    reset  = 1'b0;
    tb_cnt = 0;
    // The partial block is gone: a fresh block dumps after exactly 8 samples.
    send_block(cos_pat, 8000, 0, 0, 1'b0);
    step(1'b0, 1'b0, 0);
  endtask

  initial begin
    test_reset;
    test_dc;
    test_cos_sin;
    test_extremes;
    test_phase_sync;
    test_back_to_back_gaps;
    test_reset_midcycle;
    repeat (3) step(1'b0, 1'b0, 0);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL missing_dumps: got %0d results still pending, required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
